dmem_port_arbiter: RTL and testbench

Sequencer and arbiter in front of the byte-wide, single-ported data memory. It shares the memory between two 64-bit requesters: port 0 is the CPU load/store stage and port 1 is the memory loader/debug port. Each granted doubleword access is broken into eight byte beats, little-endian. Read bytes are assembled into a 64-bit result, and out-of-range accesses are rejected before any memory enable is driven.

---
 rtl/dmem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter/sequencer in front of a byte-wide data memory: each doubleword is split into 8 little-endian beats.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_port_arbiter #(
    parameter int MEM_SIZE = 100
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_wr0,
    input  logic        i_wr1,
    input  logic [63:0] i_add0,
    input  logic [63:0] i_add1,
    input  logic [63:0] i_dataWr0,
    input  logic [63:0] i_dataWr1,
    output logic        o_done0,
    output logic        o_done1,
    output logic        o_err0,
    output logic        o_err1,
    output logic [63:0] o_dataRd0,
    output logic [63:0] o_dataRd1,
    output logic [63:0] o_mem_add,
    output logic [7:0]  o_mem_dataWr,
    output logic        o_mem_wr,
    output logic        o_mem_rd,
    input  logic [7:0]  i_mem_dataRd
);

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    localparam logic [63:0] ADD_MAX = 64'(MEM_SIZE - 8);

    state_t      state_q, state_d;
    logic        port_q, port_d;
    logic        wr_q, wr_d;
    logic [63:0] add_q, add_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] res_q, res_d;
    logic [2:0]  beat_q, beat_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [63:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic        grant;
    logic [63:0] sel_add;
    logic        fin, fin_err;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic        last_q, last_d;

    assign grant = (i_req0 && i_req1) ? ~last_q : ~i_req0;
`else
    assign grant = ~i_req0;
`endif

    assign sel_add = grant ? i_add1 : i_add0;

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        wr_d    = wr_q;
        add_d   = add_q;
        wdata_d = wdata_q;
        res_d   = res_q;
        beat_d  = beat_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err0_d  = err0_q;
        err1_d  = err1_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        fin     = 1'b0;
        fin_err = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    port_d  = grant;
                    wr_d    = grant ? i_wr1 : i_wr0;
                    add_d   = sel_add;
                    wdata_d = grant ? i_dataWr1 : i_dataWr0;
                    beat_d  = '0;
                    res_d   = '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    last_d  = grant;
`endif
                    // Compare the base directly so a huge add cannot wrap past the limit.
                    if (sel_add > ADD_MAX) begin
                        state_d = DONE;
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        state_d = BEAT;
                    end
                end
            end
            BEAT: begin
                if (!wr_q) begin
                    res_d[{beat_q, 3'b000} +: 8] = i_mem_dataRd;
                end
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7) begin
                    state_d = DONE;
                    fin     = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Result registers load on the edge entering DONE so they are valid alongside done.
        if (fin) begin
            if (port_d) begin
                done1_d = 1'b1;
                err1_d  = fin_err;
                rd1_d   = (wr_d || fin_err) ? '0 : res_d;
            end else begin
                done0_d = 1'b1;
                err0_d  = fin_err;
                rd0_d   = (wr_d || fin_err) ? '0 : res_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            wr_q    <= 1'b0;
            add_q   <= '0;
            wdata_q <= '0;
            res_q   <= '0;
            beat_q  <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            add_q   <= add_d;
            wdata_q <= wdata_d;
            res_q   <= res_d;
            beat_q  <= beat_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        o_mem_add    = '0;
        o_mem_dataWr = '0;
        o_mem_wr     = 1'b0;
        o_mem_rd     = 1'b0;
        if (state_q == BEAT) begin
            o_mem_add    = add_q + 64'(beat_q);
            o_mem_wr     = wr_q;
            o_mem_rd     = ~wr_q;
            o_mem_dataWr = wr_q ? wdata_q[{beat_q, 3'b000} +: 8] : '0;
        end
    end

    assign o_done0   = done0_q;
    assign o_done1   = done1_q;
    assign o_err0    = err0_q;
    assign o_err1    = err1_q;
    assign o_dataRd0 = rd0_q;
    assign o_dataRd1 = rd1_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: byte memory model, vector table, tie/reset sequences and random traffic vs. a reference memory.
module tb_dmem_port_arbiter;

    localparam int MEM = 100;

    logic        i_clk, i_rst_n;
    logic        req0, req1, wr0, wr1;
    logic [63:0] add0, add1, dw0, dw1;
    logic        o_done0, o_done1, o_err0, o_err1;
    logic [63:0] o_dataRd0, o_dataRd1, o_mem_add;
    logic [7:0]  o_mem_dataWr, i_mem_dataRd;
    logic        o_mem_wr, o_mem_rd;

    logic [7:0]  mem     [0:MEM-1];
    logic [7:0]  ref_mem [0:MEM-1];

    int n_cmp = 0;
    int n_mis = 0;

    dmem_port_arbiter #(.MEM_SIZE(MEM)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req0(req0), .i_req1(req1), .i_wr0(wr0), .i_wr1(wr1),
        .i_add0(add0), .i_add1(add1), .i_dataWr0(dw0), .i_dataWr1(dw1),
        .o_done0(o_done0), .o_done1(o_done1), .o_err0(o_err0), .o_err1(o_err1),
        .o_dataRd0(o_dataRd0), .o_dataRd1(o_dataRd1),
        .o_mem_add(o_mem_add), .o_mem_dataWr(o_mem_dataWr),
        .o_mem_wr(o_mem_wr), .o_mem_rd(o_mem_rd), .i_mem_dataRd(i_mem_dataRd)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    assign i_mem_dataRd = (o_mem_add < 64'(MEM)) ? mem[int'(o_mem_add[6:0])] : 8'h00;

    always @(posedge i_clk)
        if (o_mem_wr && o_mem_add < 64'(MEM)) mem[int'(o_mem_add[6:0])] <= o_mem_dataWr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done0"}, o_done0, 0);
        check({tag, "_done1"}, o_done1, 0);
        check({tag, "_err0"}, o_err0, 0);
        check({tag, "_err1"}, o_err1, 0);
        check({tag, "_rd0"}, o_dataRd0, 0);
        check({tag, "_rd1"}, o_dataRd1, 0);
        check({tag, "_madd"}, o_mem_add, 0);
        check({tag, "_mdat"}, o_mem_dataWr, 0);
        check({tag, "_mwr"}, o_mem_wr, 0);
        check({tag, "_mrd"}, o_mem_rd, 0);
    endtask

    function automatic logic [63:0] model_rd(input logic [63:0] a);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[int'(a) + k];
        return r;
    endfunction

    // One transaction on port p, checked beat by beat; the command is scrambled after acceptance.
    task automatic do_txn(input int p, input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic exp_err, input logic [63:0] exp_rd, input string nm);
        logic [63:0] oth_rd;
        logic        oth_err, got, stray;
        oth_rd  = p ? o_dataRd0 : o_dataRd1;
        oth_err = p ? o_err0 : o_err1;
        @(negedge i_clk);
        if (p == 0) begin req0 = 1; wr0 = w; add0 = a; dw0 = d; end
        else        begin req1 = 1; wr1 = w; add1 = a; dw1 = d; end
        got = 0;
        stray = 0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge i_clk);
            if (n == 1) begin
                if (p == 0) begin wr0 = ~w; add0 = {$urandom, $urandom}; dw0 = {$urandom, $urandom}; end
                else        begin wr1 = ~w; add1 = {$urandom, $urandom}; dw1 = {$urandom, $urandom}; end
            end
            stray |= (p ? o_done0 : o_done1);
            if (p ? o_done1 : o_done0) begin
                got = 1;
                check({nm, "_lat"}, 64'(n), exp_err ? 64'd1 : 64'd9);
                check({nm, "_err"}, p ? o_err1 : o_err0, exp_err);
                check({nm, "_rd"}, p ? o_dataRd1 : o_dataRd0, exp_rd);
                check({nm, "_oth_rd"}, p ? o_dataRd0 : o_dataRd1, oth_rd);
                check({nm, "_oth_err"}, p ? o_err0 : o_err1, oth_err);
                check({nm, "_done_en"}, {o_mem_wr, o_mem_rd}, 0);
                if (p == 0) req0 = 0; else req1 = 0;
            end else if (!exp_err && n <= 8) begin
                check({nm, "_badd"}, o_mem_add, a + 64'(n - 1));
                check({nm, "_bwr"}, o_mem_wr, w);
                check({nm, "_brd"}, o_mem_rd, !w);
                if (w) check({nm, "_bdat"}, o_mem_dataWr, d[8*(n-1) +: 8]);
            end else begin
                check({nm, "_idle_en"}, {o_mem_wr, o_mem_rd}, 0);
            end
        end
        check({nm, "_done_seen"}, got, 1);
        check({nm, "_stray"}, stray, 0);
        if (got) begin
            @(negedge i_clk);
            check({nm, "_pulse"}, p ? o_done1 : o_done0, 0);
            check({nm, "_hold"}, p ? o_dataRd1 : o_dataRd0, exp_rd);
            if (w && !exp_err)
                for (int k = 0; k < 8; k++) ref_mem[int'(a) + k] = d[8*k +: 8];
        end
        if (p == 0) req0 = 0; else req1 = 0;
    endtask

    typedef struct {
        int          port;
        logic        wr;
        logic [63:0] add;
        logic [63:0] data;
        logic        err;
        logic [63:0] rd;
    } vec_t;

    vec_t tbl [9];
    int   act_q[$], exp_q[$];

    initial begin
        int          cnt0, p0_left, p1_left, last, w;
        logic        rearm, seen;
        logic [63:0] a, d;
        logic        rw, e;

        tbl[0] = '{0, 1'b1, 64'd8,  64'h1122334455667788, 1'b0, 64'h0};
        tbl[1] = '{0, 1'b0, 64'd8,  64'h0,                1'b0, 64'h1122334455667788};
        tbl[2] = '{1, 1'b1, 64'd92, 64'h0102030405060708, 1'b0, 64'h0};
        tbl[3] = '{1, 1'b0, 64'd92, 64'h0,                1'b0, 64'h0102030405060708};
        tbl[4] = '{0, 1'b1, 64'd93, 64'hDEADBEEFCAFEF00D, 1'b1, 64'h0};
        tbl[5] = '{1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0,  1'b1, 64'h0};
        tbl[6] = '{0, 1'b0, 64'd0,  64'h0,                1'b0, 64'h5D5C5F5E59585B5A};
        tbl[7] = '{1, 1'b0, 64'd84, 64'h0,                1'b0, 64'h010003020D0C0F0E};
        tbl[8] = '{0, 1'b0, 64'd92, 64'h0,                1'b0, 64'h0102030405060708};

        for (int i = 0; i < MEM; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; add0 = 0; add1 = 0; dw0 = 0; dw1 = 0;
        i_rst_n = 0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge i_clk);
        i_rst_n = 1;

        // Both ports request together; port 0 re-requests twice more right after each done.
        @(negedge i_clk);
        wr0 = 0; add0 = 0; wr1 = 0; add1 = 24; req0 = 1; req1 = 1;
        cnt0 = 0; rearm = 0;
        for (int n = 1; n <= 60 && act_q.size() < 4; n++) begin
            @(negedge i_clk);
            if (rearm) begin req0 = 1; rearm = 0; end
            if (o_done0) begin act_q.push_back(2*n); cnt0++; req0 = 0; if (cnt0 < 3) rearm = 1; end
            if (o_done1) begin act_q.push_back(2*n + 1); req1 = 0; end
        end
        req0 = 0; req1 = 0;
        p0_left = 3; p1_left = 1; last = 1;
        for (int s = 0; p0_left + p1_left > 0; s++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            if (p0_left > 0 && p1_left > 0) w = (last == 1) ? 0 : 1;
`else
            if (p0_left > 0 && p1_left > 0) w = 0;
`endif
            else w = (p0_left > 0) ? 0 : 1;
            exp_q.push_back(2*(10*s + 9) + w);
            if (w == 0) p0_left--; else p1_left--;
            last = w;
        end
        check("tie_events", 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            check("tie_evt_cycle2_plus_port", 64'(act_q[i]), 64'(exp_q[i]));

        for (int i = 0; i < 9; i++)
            do_txn(tbl[i].port, tbl[i].wr, tbl[i].add, tbl[i].data, tbl[i].err, tbl[i].rd,
                   $sformatf("vec%0d", i));

        // Reset lands during beat 3 of a port 1 write: three bytes committed, no done.
        @(negedge i_clk);
        req1 = 1; wr1 = 1; add1 = 16; dw1 = 64'hAABBCCDDEEFF0011;
        repeat (4) @(negedge i_clk);
        check("rst_beat3_add", o_mem_add, 64'd19);
        #2 i_rst_n = 0;
        #1 check_all_zero("rst_mid");
        req1 = 0; wr1 = 0;
        @(negedge i_clk);
        i_rst_n = 1;
        seen = 0;
        repeat (12) begin
            @(negedge i_clk);
            seen |= o_done1 | o_mem_wr;
        end
        check("rst_no_done_no_wr", seen, 0);
        ref_mem[16] = 8'h11; ref_mem[17] = 8'h00; ref_mem[18] = 8'hFF;
        do_txn(1, 1'b0, 64'd16, 64'h0, 1'b0, model_rd(64'd16), "rst_readback");

        for (int i = 0; i < 40; i++) begin
            a  = ($urandom_range(0, 9) == 0) ? ({$urandom, $urandom} | 64'h8000000000000000)
                                              : 64'($urandom_range(0, 100));
            d  = {$urandom, $urandom};
            rw = 1'($urandom_range(0, 1));
            e  = (a > 64'd92);
            do_txn(int'($urandom_range(0, 1)), rw, a, d, e,
                   (rw || e) ? 64'h0 : model_rd(a), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
